// File: rtl/regfile_scoreboard.sv
// Purpose : register file with NUM_RD combinational read ports, one write-back port,
//           write-through forwarding and a per-register pending-write scoreboard.
// Latency : reads and hazard flags are combinational (0 cycles); writes, pending bits
//           and pendingCount update on the rising edge of clk.
// Backpressure: none; the hazard flags tell the hazard unit when to stall issue.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   src / res / hazard       per read port: index in, data out, outstanding-write flag
//   writeBackEn/destWB/valueWB   write-back port (also clears the pending bit)
//   issueEn/issueDest        marks a destination register pending at issue
//   pendingCount/anyPending  number of pending registers and its nonzero flag
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] src,
  output logic [NUM_RD*DATA_W-1:0] res,
  output logic [NUM_RD-1:0]        hazard,
  input  logic                     writeBackEn,
  input  logic [ADDR_W-1:0]        destWB,
  input  logic [DATA_W-1:0]        valueWB,
  input  logic                     issueEn,
  input  logic [ADDR_W-1:0]        issueDest,
  output logic [CNT_W-1:0]         pendingCount,
  output logic                     anyPending
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [NREG-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cnt_inc, cnt_dec;

  // Read ports: a write to the same index this cycle is forwarded, and the
  // register then reads as ready because its data is already available.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              byp;
    assign idx = src[k*ADDR_W +: ADDR_W];
    assign byp = writeBackEn && (destWB == idx);
    assign res[k*DATA_W +: DATA_W] = byp ? valueWB : mem_q[idx];
    assign hazard[k] = pending_q[idx] && !byp;
  end

  // Clear is applied before set, so an issue to the register being written
  // back leaves it pending: the newer instruction owns the register.
  always_comb begin
    pending_d = pending_q;
    if (writeBackEn) pending_d[destWB] = 1'b0;
    if (issueEn)     pending_d[issueDest] = 1'b1;
  end

  // Incremental count: only real 0->1 and 1->0 transitions move the counter.
  // WAW issues and write-backs to idle registers leave it alone, and a
  // set/clear collision on one register is a net zero.
  always_comb begin
    cnt_inc = issueEn && !pending_q[issueDest];
    cnt_dec = writeBackEn && pending_q[destWB] &&
              !(issueEn && (issueDest == destWB));
    count_d = count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      if (writeBackEn) mem_q[destWB] <= valueWB;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pendingCount = count_q;
  assign anyPending   = (count_q != '0);

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NR   = 2;
  localparam int CW   = AW + 1;
  localparam int NREG = 16;

  logic             clk;
  logic             rst;
  logic [NR*AW-1:0] src;
  logic [NR*DW-1:0] res;
  logic [NR-1:0]    hazard;
  logic             wbe;
  logic [AW-1:0]    dwb;
  logic [DW-1:0]    vwb;
  logic             ien;
  logic [AW-1:0]    idst;
  logic [CW-1:0]    pcnt;
  logic             anyp;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural register contents and the set of
  // registers with an outstanding write.
  logic [DW-1:0] m_mem [NREG];
  bit            m_pend [NREG];

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src(src), .res(res), .hazard(hazard),
    .writeBackEn(wbe), .destWB(dwb), .valueWB(vwb),
    .issueEn(ien), .issueDest(idst),
    .pendingCount(pcnt), .anyPending(anyp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREG; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  // Compare every output with what the model predicts for the current inputs.
  task automatic check_all(input string tag);
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] s;
      bit            byp;
      s   = src[k*AW +: AW];
      byp = wbe && (dwb == s);
      chk($sformatf("%s/res%0d", tag, k), 64'(res[k*DW +: DW]),
          64'(byp ? vwb : m_mem[s]));
      chk($sformatf("%s/haz%0d", tag, k), 64'(hazard[k]),
          64'(m_pend[s] && !byp));
    end
    chk({tag, "/cnt"}, 64'(pcnt), 64'(m_count()));
    chk({tag, "/any"}, 64'(anyp), 64'(m_count() != 0));
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wbe) begin
        m_mem[dwb]  = vwb;
        m_pend[dwb] = 1'b0;
      end
      if (ien) m_pend[idst] = 1'b1;
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are checked at the
  // falling edge, then the model advances on the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wbe = 1'b0; ien = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wbe = 1'b0; dwb = '0; vwb = '0; ien = 1'b0; idst = '0; src = '0;
    @(posedge clk);
    model_update();
    #1;
    idle();
    cycle("rst0");
    chk("rst0_cnt", 64'(pcnt), 64'd0);
    chk("rst0_any", 64'(anyp), 64'd0);
    chk("rst0_haz", 64'(hazard), 64'd0);
    chk("rst0_res", 64'(res), 64'd0);

    // 1. Reset clears a written register; reset beats a same-cycle write.
    wbe = 1'b1; dwb = 4'd3; vwb = 32'hDEADBEEF;
    cycle("t1_wr");
    idle(); src = {4'd3, 4'd3};
    #1 chk("t1_wr_res", 64'(res[DW-1:0]), 64'hDEADBEEF);
    rst = 1'b1;
    cycle("t1_rst");
    idle();
    #1;
    chk("t1_res", 64'(res[DW-1:0]), 64'd0);
    chk("t1_cnt", 64'(pcnt), 64'd0);
    chk("t1_haz", 64'(hazard), 64'd0);
    wbe = 1'b1; dwb = 4'd3; vwb = 32'hDEADBEEF;
    cycle("t1_wr2");
    rst = 1'b1; wbe = 1'b1; dwb = 4'd3; vwb = 32'hCAFEF00D;
    cycle("t1_rstwr");
    idle();
    #1 chk("t1_rstwr_res", 64'(res[DW-1:0]), 64'd0);

    // 2. Write-through bypass on both ports, then the stored value.
    wbe = 1'b1; dwb = 4'd5; vwb = 32'h1234; src = {4'd5, 4'd5};
    #1;
    chk("t2_byp0", 64'(res[DW-1:0]), 64'h1234);
    chk("t2_byp1", 64'(res[2*DW-1:DW]), 64'h1234);
    cycle("t2");
    idle();
    #1;
    chk("t2_hold0", 64'(res[DW-1:0]), 64'h1234);
    chk("t2_hold1", 64'(res[2*DW-1:DW]), 64'h1234);

    // 3. Scoreboard: issue R2, R7; write back R2 with forwarding.
    ien = 1'b1; idst = 4'd2;
    cycle("t3_i2");
    chk("t3_cnt1", 64'(pcnt), 64'd1);
    idst = 4'd7;
    cycle("t3_i7");
    idle();
    chk("t3_cnt2", 64'(pcnt), 64'd2);
    src = {4'd7, 4'd2};
    #1 chk("t3_haz", 64'(hazard), 64'b11);
    wbe = 1'b1; dwb = 4'd2; vwb = 32'hAAAA0002;
    #1;
    chk("t3_haz_wb", 64'(hazard[0]), 64'd0);
    chk("t3_res_wb", 64'(res[DW-1:0]), 64'hAAAA0002);
    cycle("t3_wb");
    idle();
    chk("t3_cnt_after", 64'(pcnt), 64'd1);

    // 4. Set and clear on the same register: set wins, count unchanged.
    ien = 1'b1; idst = 4'd4;
    cycle("t4_i4");
    chk("t4_cnt_pre", 64'(pcnt), 64'd2);
    ien = 1'b1; idst = 4'd4; wbe = 1'b1; dwb = 4'd4; vwb = 32'h44444444;
    cycle("t4_coll");
    idle(); src = {4'd0, 4'd4};
    #1;
    chk("t4_haz", 64'(hazard[0]), 64'd1);
    chk("t4_cnt", 64'(pcnt), 64'd2);

    // 5. Issue R9 while R1 is written back: count net zero.
    ien = 1'b1; idst = 4'd1;
    cycle("t5_i1");
    ien = 1'b1; idst = 4'd9; wbe = 1'b1; dwb = 4'd1; vwb = 32'h11111111;
    cycle("t5_cross");
    idle(); src = {4'd9, 4'd1};
    #1;
    chk("t5_cnt", 64'(pcnt), 64'd3);
    chk("t5_haz", 64'(hazard), 64'b10);

    // 6. Saturation, WAW reissue, drain, extra write to an idle register.
    for (int i = 0; i < NREG; i++) begin
      ien = 1'b1; idst = AW'(i);
      cycle("t6_iss");
    end
    idst = 4'd0;
    cycle("t6_waw");
    idle();
    chk("t6_cnt_full", 64'(pcnt), 64'd16);
    chk("t6_any_full", 64'(anyp), 64'd1);
    for (int i = 0; i < NREG; i++) begin
      wbe = 1'b1; dwb = AW'(i); vwb = 32'h5000 + 32'(i) * 32'h111;
      cycle("t6_wb");
    end
    wbe = 1'b1; dwb = 4'd0; vwb = 32'hFACE0000;
    cycle("t6_extra");
    idle(); src = {4'd15, 4'd0};
    #1;
    chk("t6_cnt_empty", 64'(pcnt), 64'd0);
    chk("t6_any_empty", 64'(anyp), 64'd0);
    chk("t6_r0", 64'(res[DW-1:0]), 64'hFACE0000);
    chk("t6_r15", 64'(res[2*DW-1:DW]), 64'h5000 + 64'd15 * 64'h111);

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      wbe  = $urandom_range(0, 1) == 1;
      ien  = $urandom_range(0, 2) != 0;
      dwb  = AW'($urandom_range(0, NREG - 1));
      idst = ($urandom_range(0, 3) == 0) ? dwb : AW'($urandom_range(0, NREG - 1));
      vwb  = $urandom;
      src  = {AW'($urandom_range(0, NREG - 1)),
              ($urandom_range(0, 2) == 0) ? dwb : AW'($urandom_range(0, NREG - 1))};
      cycle("rnd");
    end
    idle();
    cycle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
